// File: rtl/img_capture_packer.sv
// Frame-capture engine: arms, syncs to the next FVAL rise and packs DVAL pixels into wide memory words.
// Optional IMG_CAP_THRESH_EN adds i_thresh and stores each pixel binarised (all-ones / zero).
module img_capture_packer #(
    parameter int PXL_W         = 16,
    parameter int PXLS_PER_WORD = 16,
    parameter int IMG_W         = 28,
    parameter int IMG_H         = 28,
    parameter int ADDR_W        = 7,
    parameter int BASE_ADDR     = 0
) (
    input  logic                             pxlclk,
    input  logic                             rst,
    input  logic                             i_enable,
    input  logic                             i_start,
    input  logic                             i_cont,
    input  logic                             i_fval,
    input  logic                             i_dval,
    input  logic [PXL_W-1:0]                 i_data,
`ifdef IMG_CAP_THRESH_EN
    input  logic [PXL_W-1:0]                 i_thresh,
`endif
    output logic                             o_wren,
    output logic [ADDR_W-1:0]                o_addr,
    output logic [PXL_W*PXLS_PER_WORD-1:0]   o_data,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_err
);

    localparam int WORD_W = PXL_W * PXLS_PER_WORD;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NWORDS = (NPIX + PXLS_PER_WORD - 1) / PXLS_PER_WORD;
    localparam int CNT_W  = $clog2(NPIX + 1);
    localparam int LANE_W = (PXLS_PER_WORD > 1) ? $clog2(PXLS_PER_WORD) : 1;
    localparam int WIDX_W = $clog2(NWORDS + 1);

    if (longint'(BASE_ADDR) + longint'(NWORDS) - 1 >= (longint'(1) << ADDR_W)) begin : g_addr_chk
        $error("img_capture_packer: BASE_ADDR+NWORDS-1 does not fit in ADDR_W bits");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    state_t              state;
    logic                fval_q;
    logic [WORD_W-1:0]   lane_buf;
    logic [CNT_W-1:0]    pix_cnt;
    logic [LANE_W-1:0]   lane;
    logic [WIDX_W-1:0]   widx;

    logic                frame_start;
    logic                accept;
    logic                restart;
    logic                last_pix;
    logic                last_lane;
    logic [PXL_W-1:0]    pix_val;
    logic [WORD_W-1:0]   wr_word;

    assign frame_start = i_fval & ~fval_q;
    assign last_pix    = (pix_cnt == CNT_W'(NPIX - 1));
    assign last_lane   = (lane == LANE_W'(PXLS_PER_WORD - 1));

    // A pixel is taken either in CAPTURE or on the very FVAL-rise cycle that leaves ARMED.
    assign accept = i_enable & i_fval & i_dval &
                    ((state == S_CAPTURE) | ((state == S_ARMED) & frame_start));

    // Any path back to IDLE/ARMED starts the next frame from a clean buffer.
    assign restart = ~i_enable |
                     ((state == S_IDLE) & i_start) |
                     ((state == S_CAPTURE) & ~i_fval) |
                     (state == S_FLUSH);

    always_comb begin
`ifdef IMG_CAP_THRESH_EN
        pix_val = (i_data >= i_thresh) ? {PXL_W{1'b1}} : {PXL_W{1'b0}};
`else
        pix_val = i_data;
`endif
        wr_word = lane_buf;
        wr_word[lane*PXL_W +: PXL_W] = pix_val;
    end

    always_ff @(posedge pxlclk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            fval_q   <= 1'b0;
            lane_buf <= '0;
            pix_cnt  <= '0;
            lane     <= '0;
            widx     <= '0;
            o_wren   <= 1'b0;
            o_addr   <= ADDR_W'(BASE_ADDR);
            o_data   <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            fval_q <= i_fval;
            o_wren <= 1'b0;
            o_done <= 1'b0;
            o_err  <= 1'b0;

            if (!i_enable) begin
                state  <= S_IDLE;
                o_busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start) begin
                            state  <= S_ARMED;
                            o_busy <= 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (frame_start) state <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        if (!i_fval) begin
                            o_err  <= 1'b1;
                            state  <= i_cont ? S_ARMED : S_IDLE;
                            o_busy <= i_cont;
                        end
                    end
                    S_FLUSH: begin
                        o_done <= 1'b1;
                        state  <= i_cont ? S_ARMED : S_IDLE;
                        o_busy <= i_cont;
                    end
                    default: begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
                if (accept && last_pix) state <= S_FLUSH;
            end

            if (restart) begin
                lane_buf <= '0;
                pix_cnt  <= '0;
                lane     <= '0;
                widx     <= '0;
            end else if (accept) begin
                pix_cnt <= pix_cnt + 1'b1;
                // The final pixel issues the write itself, so a partial word lands 1 cycle later too.
                if (last_lane || last_pix) begin
                    o_wren   <= 1'b1;
                    o_data   <= wr_word;
                    o_addr   <= ADDR_W'(BASE_ADDR) + ADDR_W'(widx);
                    lane_buf <= '0;
                    lane     <= '0;
                    widx     <= widx + 1'b1;
                end else begin
                    lane_buf <= wr_word;
                    lane     <= lane + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_img_capture_packer.sv
// Scoreboard bench for img_capture_packer: a 5x5 instance for the directed cases and a default 28x28 instance.
// Build with IMG_CAP_THRESH_EN defined to also exercise the binarising path.
module tb_img_capture_packer;

    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    typedef struct packed {
        logic [1:0]   kind;
        logic [6:0]   addr;
        logic [255:0] data;
        logic [31:0]  cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic en_s, en_b, start, cont, fval, dval;
    logic [15:0] data;
`ifdef IMG_CAP_THRESH_EN
    logic [15:0] thresh;
`endif
    logic         s_wren, s_busy, s_done, s_err;
    logic [6:0]   s_addr;
    logic [255:0] s_data;
    logic         b_wren, b_busy, b_done, b_err;
    logic [6:0]   b_addr;
    logic [255:0] b_data;

    logic [31:0] cyc = 32'd0;
    ev_t q_s[$];
    ev_t q_b[$];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    img_capture_packer #(.IMG_W(5), .IMG_H(5)) dut_s (
        .pxlclk(clk), .rst(rst), .i_enable(en_s), .i_start(start), .i_cont(cont),
        .i_fval(fval), .i_dval(dval), .i_data(data),
`ifdef IMG_CAP_THRESH_EN
        .i_thresh(thresh),
`endif
        .o_wren(s_wren), .o_addr(s_addr), .o_data(s_data),
        .o_busy(s_busy), .o_done(s_done), .o_err(s_err)
    );

    img_capture_packer dut_b (
        .pxlclk(clk), .rst(rst), .i_enable(en_b), .i_start(start), .i_cont(cont),
        .i_fval(fval), .i_dval(dval), .i_data(data),
`ifdef IMG_CAP_THRESH_EN
        .i_thresh(thresh),
`endif
        .o_wren(b_wren), .o_addr(b_addr), .o_data(b_data),
        .o_busy(b_busy), .o_done(b_done), .o_err(b_err)
    );

    function automatic logic [15:0] px(input int v);
`ifdef IMG_CAP_THRESH_EN
        return (16'(v) >= thresh) ? 16'hFFFF : 16'h0000;
`else
        return 16'(v);
`endif
    endfunction

    // Word whose lane i holds pixel value first+i for i<n, remaining lanes zero.
    function automatic logic [255:0] mk_word(input int first, input int n);
        logic [255:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[i*16 +: 16] = px(first + i);
        return w;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic push(input bit big, input logic [1:0] kind, input int addr,
                        input logic [255:0] d, input logic [31:0] at);
        ev_t e;
        e.kind = kind;
        e.addr = 7'(addr);
        e.data = d;
        e.cyc  = at;
        if (big) q_b.push_back(e);
        else q_s.push_back(e);
    endtask

    task automatic see(input bit big, input logic [1:0] kind, input logic [6:0] addr, input logic [255:0] d);
        ev_t e;
        n_chk++;
        if ((big && q_b.size() == 0) || (!big && q_s.size() == 0)) begin
            $display("FAIL %s_event: got unexpected kind=%0d addr=%0d at cycle %0d, required no output",
                     big ? "big" : "small", kind, addr, cyc);
            return;
        end
        e = big ? q_b.pop_front() : q_s.pop_front();
        if (e.kind === kind && e.addr === addr && e.data === d && e.cyc === cyc) n_pass++;
        else $display("FAIL %s_event: got kind=%0d addr=%0d cyc=%0d data=%h, required kind=%0d addr=%0d cyc=%0d data=%h",
                      big ? "big" : "small", kind, addr, cyc, d, e.kind, e.addr, e.cyc, e.data);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (s_wren) see(1'b0, K_WR, s_addr, s_data);
            if (s_done) see(1'b0, K_DONE, 7'd0, '0);
            if (s_err)  see(1'b0, K_ERR, 7'd0, '0);
            if (b_wren) see(1'b1, K_WR, b_addr, b_data);
            if (b_done) see(1'b1, K_DONE, 7'd0, '0);
            if (b_err)  see(1'b1, K_ERR, 7'd0, '0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    // Pixel i of the frame is driven in cycle (cyc at call)+1+i; FVAL drops right after the last one.
    task automatic frame(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            tick();
            fval = 1'b1;
            dval = 1'b1;
            data = 16'(first + i);
        end
        tick();
        fval = 1'b0;
        dval = 1'b0;
        data = 16'h0;
    endtask

    // Expected writes/done of a complete 5x5 frame whose first pixel is driven in cycle c0.
    task automatic exp_small_frame(input int first, input logic [31:0] c0);
        push(1'b0, K_WR, 0, mk_word(first, 16), c0 + 32'd16);
        push(1'b0, K_WR, 1, mk_word(first + 16, 9), c0 + 32'd25);
        push(1'b0, K_DONE, 0, '0, c0 + 32'd26);
    endtask

    logic [31:0] c0;

    initial begin
        rst = 1'b1; en_s = 1'b0; en_b = 1'b0; start = 1'b0; cont = 1'b0;
        fval = 1'b0; dval = 1'b0; data = 16'h0;
`ifdef IMG_CAP_THRESH_EN
        thresh = 16'h0000;
`endif
        idle(3);
        check("rst_wren", 256'(s_wren), 256'd0);
        check("rst_addr", 256'(s_addr), 256'd0);
        check("rst_data", s_data, 256'd0);
        check("rst_busy", 256'(s_busy), 256'd0);
        check("rst_done", 256'(s_done), 256'd0);
        check("rst_err",  256'(s_err),  256'd0);
        rst = 1'b0;
        en_s = 1'b1;
        idle(2);

        // Single frame, pixels 1..25, then back to IDLE.
        arm();
        check("armed_busy", 256'(s_busy), 256'd1);
        c0 = cyc + 32'd1;
        exp_small_frame(1, c0);
        frame(25, 1);
        idle(3);
        check("idle_after_done", 256'(s_busy), 256'd0);

        // Pixels past NPIX in the same frame are ignored.
        arm();
        c0 = cyc + 32'd1;
        exp_small_frame(201, c0);
        frame(27, 201);
        idle(3);

        // Armed while a frame is already running: that frame is skipped.
        fval = 1'b1; dval = 1'b1; data = 16'h0055;
        idle(2);
        arm();
        idle(3);
        fval = 1'b0; dval = 1'b0;
        tick();
        check("skip_busy", 256'(s_busy), 256'd1);
        c0 = cyc + 32'd1;
        exp_small_frame(101, c0);
        frame(25, 101);
        idle(3);

        // FVAL falls after 20 pixels: one write, an error pulse, no done.
        arm();
        c0 = cyc + 32'd1;
        push(1'b0, K_WR, 0, mk_word(1, 16), c0 + 32'd16);
        push(1'b0, K_ERR, 0, '0, c0 + 32'd21);
        frame(20, 1);
        idle(3);
        check("abort_idle", 256'(s_busy), 256'd0);

        // Continuous mode, two back-to-back frames, then enable low.
        cont = 1'b1;
        arm();
        c0 = cyc + 32'd1;
        exp_small_frame(1, c0);
        frame(25, 1);
        c0 = cyc + 32'd1;
        exp_small_frame(51, c0);
        frame(25, 51);
        idle(3);
        check("cont_rearmed", 256'(s_busy), 256'd1);
        en_s = 1'b0;
        idle(2);
        check("enable_low_idle", 256'(s_busy), 256'd0);
        en_s = 1'b1;
        cont = 1'b0;
        idle(2);

        // Reset in the middle of the second word.
        arm();
        c0 = cyc + 32'd1;
        push(1'b0, K_WR, 0, mk_word(1, 16), c0 + 32'd16);
        for (int i = 0; i < 17; i++) begin
            tick();
            fval = 1'b1; dval = 1'b1; data = 16'(1 + i);
        end
        tick();
        check("pre_rst_data_hold", s_data, mk_word(1, 16));
        rst = 1'b1;
        #1;
        check("midrst_wren", 256'(s_wren), 256'd0);
        check("midrst_addr", 256'(s_addr), 256'd0);
        check("midrst_data", s_data, 256'd0);
        check("midrst_busy", 256'(s_busy), 256'd0);
        check("midrst_done", 256'(s_done), 256'd0);
        check("midrst_err",  256'(s_err),  256'd0);
        idle(2);
        rst = 1'b0;
        for (int i = 17; i < 25; i++) begin
            tick();
            data = 16'(1 + i);
        end
        tick();
        fval = 1'b0; dval = 1'b0;
        idle(4);

`ifdef IMG_CAP_THRESH_EN
        // Binarised capture: 0x70..0x7F -> 0, 0x80..0x88 -> all ones.
        thresh = 16'h0080;
        arm();
        c0 = cyc + 32'd1;
        push(1'b0, K_WR, 0, 256'd0, c0 + 32'd16);
        push(1'b0, K_WR, 1, {112'd0, {9{16'hFFFF}}}, c0 + 32'd25);
        push(1'b0, K_DONE, 0, '0, c0 + 32'd26);
        frame(25, 16'h0070);
        idle(3);
        thresh = 16'h0000;
`endif

        // Default 28x28 instance: 49 full words, one done, no extra write.
        en_s = 1'b0;
        en_b = 1'b1;
        idle(1);
        arm();
        c0 = cyc + 32'd1;
        for (int w = 0; w < 49; w++)
            push(1'b1, K_WR, w, mk_word(16 * w + 1, 16), c0 + 32'(16 * w + 16));
        push(1'b1, K_DONE, 0, '0, c0 + 32'd785);
        frame(784, 1);
        idle(4);
        check("big_idle", 256'(b_busy), 256'd0);
        en_b = 1'b0;
        idle(3);

        check("small_queue_drained", 256'(q_s.size()), 256'd0);
        check("big_queue_drained", 256'(q_b.size()), 256'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
